// File: rtl/ecc_scrub_ctrl_pkg.sv
// Shared types and helpers for the ECC scrub controller and its SECDED codec partners.
// Holds the FSM encoding, Hamming sizing helpers and the saturating counter step.
package ecc_scrub_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HRD_WAIT,
    SRD_WAIT,
    WB
  } state_t;

  // Smallest M with 2^M >= M+K+1, same rule hamming_dec/hamming_enc use.
  function automatic int calc_m(input int k);
    int m;
    m = 1;
    while ((1 << m) < (m + k + 1)) m++;
    return m;
  endfunction

  function automatic int calc_cw_w(input int k);
    return k + calc_m(k) + 1;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ecc_scrub_ctrl_if.sv
// Bundles the host, SRAM, codec and status signals of ecc_scrub_ctrl.
// The controller takes the slave side; the surrounding logic takes master.
interface ecc_scrub_ctrl_if #(
  parameter int K      = 4,
  parameter int CW_W   = 8,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
);
  logic              host_req_i;
  logic [ADDR_W-1:0] host_addr_i;
  logic              host_gnt_o;
  logic              rsp_valid_o;
  logic [K-1:0]      rsp_data_o;
  logic              rsp_sb_err_o;
  logic              rsp_db_err_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [CW_W-1:0]   mem_wdata_o;
  logic [CW_W-1:0]   mem_rdata_i;
  logic [CW_W-1:0]   dec_cw_o;
  logic [K-1:0]      dec_q_i;
  logic              dec_sb_err_i;
  logic              dec_db_err_i;
  logic [K-1:0]      enc_data_o;
  logic [CW_W-1:0]   enc_cw_i;
  logic [CNT_W-1:0]  sb_cnt_o;
  logic [CNT_W-1:0]  db_cnt_o;
  logic [ADDR_W-1:0] db_addr_o;
  logic              db_irq_o;

  modport slave (
    input  host_req_i, host_addr_i, mem_rdata_i, dec_q_i, dec_sb_err_i, dec_db_err_i, enc_cw_i,
    output host_gnt_o, rsp_valid_o, rsp_data_o, rsp_sb_err_o, rsp_db_err_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, dec_cw_o, enc_data_o,
           sb_cnt_o, db_cnt_o, db_addr_o, db_irq_o
  );

  modport master (
    output host_req_i, host_addr_i, mem_rdata_i, dec_q_i, dec_sb_err_i, dec_db_err_i, enc_cw_i,
    input  host_gnt_o, rsp_valid_o, rsp_data_o, rsp_sb_err_o, rsp_db_err_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, dec_cw_o, enc_data_o,
           sb_cnt_o, db_cnt_o, db_addr_o, db_irq_o
  );
endinterface

// File: rtl/ecc_scrub_timer.sv
// Free-running scrub interval counter; raises a single pending slot per expiry.
// Expiries while a slot is already pending are dropped rather than queued.
module ecc_scrub_timer #(
  parameter int SCRUB_INTERVAL = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en,
  input  logic take,
  output logic pending
);
  localparam int TW = (SCRUB_INTERVAL > 2) ? $clog2(SCRUB_INTERVAL) : 1;
  localparam logic [TW-1:0] LAST = TW'(SCRUB_INTERVAL - 1);

  logic [TW-1:0] cnt_reg;
  logic          pending_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_reg     <= '0;
      pending_reg <= 1'b0;
    end else if (!en) begin
      pending_reg <= 1'b0;
    end else begin
      cnt_reg <= (cnt_reg == LAST) ? '0 : cnt_reg + 1'b1;
      if (take)
        pending_reg <= 1'b0;
      else if (cnt_reg == LAST)
        pending_reg <= 1'b1;
    end
  end

  assign pending = pending_reg;
endmodule

// File: rtl/ecc_scrub_ctrl.sv
// Sequences host reads and background scrubs through an external SECDED codec,
// writing corrected words back and logging uncorrectable ones.
module ecc_scrub_ctrl
  import ecc_scrub_ctrl_pkg::*;
#(
  parameter int K              = 4,
  parameter int M              = calc_m(K),
  parameter int CW_W           = K + M + 1,
  parameter int ADDR_W         = 8,
  parameter int SCRUB_INTERVAL = 1024,
  parameter int CNT_W          = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            scrub_en_i,
  input  logic            clr_i,
  ecc_scrub_ctrl_if.slave bus
);
  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] ptr_reg, addr_reg, db_addr_reg;
  logic [K-1:0]      data_reg, rsp_data_reg;
  logic              last_was_host_reg, rsp_valid_reg, rsp_sb_reg, rsp_db_reg, db_irq_reg;
  logic [CNT_W-1:0]  sb_cnt_reg, db_cnt_reg;
  logic              scrub_pending, scrub_take, host_take, rd_phase, sb_ev, db_ev;

  ecc_scrub_timer #(.SCRUB_INTERVAL(SCRUB_INTERVAL)) u_timer (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en     (scrub_en_i),
    .take   (scrub_take),
    .pending(scrub_pending)
  );

  // A double error masks a simultaneous single-error flag.
  assign rd_phase = (state_reg == HRD_WAIT) || (state_reg == SRD_WAIT);
  assign db_ev    = rd_phase && bus.dec_db_err_i;
  assign sb_ev    = rd_phase && bus.dec_sb_err_i && !bus.dec_db_err_i;

  always_comb begin
    state_next      = state_reg;
    scrub_take      = 1'b0;
    host_take       = 1'b0;
    bus.host_gnt_o  = 1'b0;
    bus.mem_req_o   = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    bus.dec_cw_o    = '0;
    bus.enc_data_o  = '0;
    case (state_reg)
      IDLE: begin
        if (rst_ni) begin
          if (scrub_pending && (!bus.host_req_i || last_was_host_reg)) begin
            scrub_take     = 1'b1;
            bus.mem_req_o  = 1'b1;
            bus.mem_addr_o = ptr_reg;
            state_next     = SRD_WAIT;
          end else if (bus.host_req_i) begin
            host_take      = 1'b1;
            bus.host_gnt_o = 1'b1;
            bus.mem_req_o  = 1'b1;
            bus.mem_addr_o = bus.host_addr_i;
            state_next     = HRD_WAIT;
          end
        end
      end
      HRD_WAIT, SRD_WAIT: begin
        bus.dec_cw_o = bus.mem_rdata_i;
        state_next   = sb_ev ? WB : IDLE;
      end
      WB: begin
        bus.enc_data_o  = data_reg;
        bus.mem_req_o   = 1'b1;
        bus.mem_we_o    = 1'b1;
        bus.mem_addr_o  = addr_reg;
        bus.mem_wdata_o = bus.enc_cw_i;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg         <= IDLE;
      ptr_reg           <= '0;
      addr_reg          <= '0;
      db_addr_reg       <= '0;
      data_reg          <= '0;
      rsp_data_reg      <= '0;
      last_was_host_reg <= 1'b0;
      rsp_valid_reg     <= 1'b0;
      rsp_sb_reg        <= 1'b0;
      rsp_db_reg        <= 1'b0;
      db_irq_reg        <= 1'b0;
      sb_cnt_reg        <= '0;
      db_cnt_reg        <= '0;
    end else begin
      state_reg <= state_next;
      if (host_take) begin
        addr_reg          <= bus.host_addr_i;
        last_was_host_reg <= 1'b1;
      end
      if (scrub_take) begin
        addr_reg          <= ptr_reg;
        last_was_host_reg <= 1'b0;
      end
      if (sb_ev)
        data_reg <= bus.dec_q_i;
      rsp_valid_reg <= (state_reg == HRD_WAIT);
      rsp_sb_reg    <= (state_reg == HRD_WAIT) && sb_ev;
      rsp_db_reg    <= (state_reg == HRD_WAIT) && db_ev;
      if (state_reg == HRD_WAIT)
        rsp_data_reg <= bus.dec_q_i;
      if (state_reg == SRD_WAIT) begin
        ptr_reg <= ptr_reg + 1'b1;
        if (db_ev) begin
          db_addr_reg <= ptr_reg;
          db_irq_reg  <= 1'b1;
        end
      end
      // Clear overrides any error event landing in the same cycle.
      if (clr_i) begin
        sb_cnt_reg <= '0;
        db_cnt_reg <= '0;
        db_irq_reg <= 1'b0;
      end else begin
        if (sb_ev) sb_cnt_reg <= CNT_W'(sat_inc(32'(sb_cnt_reg), CNT_W));
        if (db_ev) db_cnt_reg <= CNT_W'(sat_inc(32'(db_cnt_reg), CNT_W));
      end
    end
  end

  assign bus.rsp_valid_o  = rsp_valid_reg;
  assign bus.rsp_data_o   = rsp_data_reg;
  assign bus.rsp_sb_err_o = rsp_sb_reg;
  assign bus.rsp_db_err_o = rsp_db_reg;
  assign bus.sb_cnt_o     = sb_cnt_reg;
  assign bus.db_cnt_o     = db_cnt_reg;
  assign bus.db_addr_o    = db_addr_reg;
  assign bus.db_irq_o     = db_irq_reg;
endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Directed bench: SRAM + SECDED(8,4) models around two controller instances
// (full-size, and a 4-word/2-bit-counter one for pointer wrap and saturation).
module tb_ecc_scrub_ctrl;
  typedef struct packed {logic [3:0] q; logic sb; logic db;} dec_t;
  typedef struct {logic [7:0] addr; logic [7:0] cw; logic [3:0] q; logic sb; logic db;} vec_t;

  logic clk = 1'b0;
  logic rst_n, scrub_en, clr, scrub_en2, clr2;
  always #5 clk = ~clk;

  ecc_scrub_ctrl_if #(.K(4), .CW_W(8), .ADDR_W(8), .CNT_W(16)) bus ();
  ecc_scrub_ctrl_if #(.K(4), .CW_W(8), .ADDR_W(2), .CNT_W(2))  bus2 ();

  ecc_scrub_ctrl #(.K(4), .M(3), .CW_W(8), .ADDR_W(8), .SCRUB_INTERVAL(8), .CNT_W(16)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .scrub_en_i(scrub_en), .clr_i(clr), .bus(bus));
  ecc_scrub_ctrl #(.K(4), .M(3), .CW_W(8), .ADDR_W(2), .SCRUB_INTERVAL(4), .CNT_W(2)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .scrub_en_i(scrub_en2), .clr_i(clr2), .bus(bus2));

  function automatic logic [7:0] enc(input logic [3:0] d);
    logic [7:0] c;
    c = '0;
    c[3] = d[0]; c[5] = d[1]; c[6] = d[2]; c[7] = d[3];
    c[1] = d[0] ^ d[1] ^ d[3];
    c[2] = d[0] ^ d[2] ^ d[3];
    c[4] = d[1] ^ d[2] ^ d[3];
    c[0] = ^c[7:1];
    return c;
  endfunction

  function automatic dec_t dec(input logic [7:0] cw);
    dec_t r;
    logic [2:0] syn;
    logic [7:0] c;
    c = cw; syn = '0; r.sb = 1'b0; r.db = 1'b0;
    for (int p = 1; p < 8; p++) if (c[p]) syn ^= 3'(p);
    if (^c) begin
      r.sb = 1'b1;
      if (syn != 3'd0) c[syn] = ~c[syn];
    end else if (syn != 3'd0) begin
      r.db = 1'b1;
    end
    r.q = {c[7], c[6], c[5], c[3]};
    return r;
  endfunction

  dec_t d1, d2;
  always_comb begin
    d1 = dec(bus.dec_cw_o);
    bus.dec_q_i = d1.q; bus.dec_sb_err_i = d1.sb; bus.dec_db_err_i = d1.db;
    bus.enc_cw_i = enc(bus.enc_data_o);
    d2 = dec(bus2.dec_cw_o);
    bus2.dec_q_i = d2.q; bus2.dec_sb_err_i = d2.sb; bus2.dec_db_err_i = d2.db;
    bus2.enc_cw_i = enc(bus2.enc_data_o);
  end

  logic [7:0] mem1 [256];
  logic [7:0] mem2 [4];
  logic       mem_init, pl_we, log_en, log2_en;
  logic [7:0] pl_addr, pl_data, last_wr_addr, last_wr_data;
  int         wr_cnt, nlog, n2;
  logic [7:0] log_addr [64];
  logic       log_host [64];
  logic [1:0] log2_addr [64];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem1[i] <= 8'h00;
    end else if (pl_we) begin
      mem1[pl_addr] <= pl_data;
    end else if (bus.mem_req_o && bus.mem_we_o) begin
      mem1[bus.mem_addr_o] <= bus.mem_wdata_o;
      wr_cnt       <= wr_cnt + 1;
      last_wr_addr <= bus.mem_addr_o;
      last_wr_data <= bus.mem_wdata_o;
    end
    if (bus.mem_req_o && !bus.mem_we_o) bus.mem_rdata_i <= mem1[bus.mem_addr_o];
    if (!log_en) nlog <= 0;
    else if (bus.mem_req_o && !bus.mem_we_o && nlog < 64) begin
      log_addr[nlog] <= bus.mem_addr_o;
      log_host[nlog] <= bus.host_gnt_o;
      nlog <= nlog + 1;
    end
  end

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 4; i++) mem2[i] <= 8'h03;
    end else if (bus2.mem_req_o && bus2.mem_we_o) begin
      mem2[bus2.mem_addr_o] <= bus2.mem_wdata_o;
    end
    if (bus2.mem_req_o && !bus2.mem_we_o) bus2.mem_rdata_i <= mem2[bus2.mem_addr_o];
    if (!log2_en) n2 <= 0;
    else if (bus2.mem_req_o && !bus2.mem_we_o && n2 < 64) begin
      log2_addr[n2] <= bus2.mem_addr_o;
      n2 <= n2 + 1;
    end
  end

  int n_chk = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    cyc(1);
    pl_we = 1'b0;
  endtask

  // Called at posedge+1; returns cycles from grant to rsp_valid (-1 on timeout).
  task automatic host_read(input logic [7:0] a, output logic [3:0] q, output logic sb,
                           output logic db, output int lat);
    int  t;
    bit  got;
    bus.host_req_i = 1'b1; bus.host_addr_i = a;
    got = 0; t = 0;
    while (!got && t < 20) begin
      #1;
      if (bus.host_gnt_o) got = 1;
      else begin @(posedge clk); #1; t++; end
    end
    @(posedge clk); #1;
    bus.host_req_i = 1'b0;
    lat = -1; q = 'x; sb = 1'bx; db = 1'bx;
    if (got) begin
      got = 0; t = 1;
      while (!got && t < 6) begin
        if (bus.rsp_valid_o) got = 1;
        else begin @(posedge clk); #1; t++; end
      end
      if (got) begin
        lat = t; q = bus.rsp_data_o; sb = bus.rsp_sb_err_o; db = bus.rsp_db_err_o;
      end
    end
  endtask

  vec_t       vt [6];
  logic [3:0] q;
  logic       sb, db;
  int         lat, w0, t, ns, nh, cons;

  initial begin
    rst_n = 1'b0; scrub_en = 1'b0; clr = 1'b0; scrub_en2 = 1'b0; clr2 = 1'b0;
    bus.host_req_i = 1'b0; bus.host_addr_i = '0; bus2.host_req_i = 1'b0; bus2.host_addr_i = '0;
    mem_init = 1'b1; pl_we = 1'b0; pl_addr = '0; pl_data = '0; log_en = 1'b0; log2_en = 1'b0;
    vt[0] = '{8'h05, enc(4'hA),         4'hA, 1'b0, 1'b0};
    vt[1] = '{8'h10, enc(4'h6) ^ 8'h08, 4'h6, 1'b1, 1'b0};
    vt[2] = '{8'h11, enc(4'h3) ^ 8'h01, 4'h3, 1'b1, 1'b0};
    vt[3] = '{8'h20, enc(4'h9) ^ 8'h0C, 4'h8, 1'b0, 1'b1};
    vt[4] = '{8'hFF, enc(4'hF),         4'hF, 1'b0, 1'b0};
    vt[5] = '{8'h00, enc(4'h0) ^ 8'h80, 4'h0, 1'b1, 1'b0};

    cyc(2);
    mem_init = 1'b0;
    bus.host_req_i = 1'b1;
    #1;
    check("rst_gnt", bus.host_gnt_o, 0);
    check("rst_mem_req", bus.mem_req_o, 0);
    check("rst_rsp_valid", bus.rsp_valid_o, 0);
    check("rst_sb_cnt", bus.sb_cnt_o, 0);
    check("rst_db_cnt", bus.db_cnt_o, 0);
    check("rst_db_irq", bus.db_irq_o, 0);
    check("rst_db_addr", bus.db_addr_o, 0);
    bus.host_req_i = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(2);

    for (int i = 0; i < 6; i++) begin
      preload(vt[i].addr, vt[i].cw);
      w0 = wr_cnt;
      host_read(vt[i].addr, q, sb, db, lat);
      $display("host read addr=%02h cw=%02h -> data=%h sb=%b db=%b latency=%0d",
               vt[i].addr, vt[i].cw, q, sb, db, lat);
      check($sformatf("v%0d_latency", i), lat, 2);
      check($sformatf("v%0d_data", i), q, vt[i].q);
      check($sformatf("v%0d_sb", i), sb, vt[i].sb);
      check($sformatf("v%0d_db", i), db, vt[i].db);
      cyc(2);
      check($sformatf("v%0d_writes", i), wr_cnt - w0, vt[i].sb ? 1 : 0);
      if (vt[i].sb) begin
        check($sformatf("v%0d_wb_addr", i), last_wr_addr, vt[i].addr);
        check($sformatf("v%0d_wb_data", i), last_wr_data, enc(vt[i].q));
      end
    end
    check("sb_cnt_after_table", bus.sb_cnt_o, 3);
    check("db_cnt_after_table", bus.db_cnt_o, 1);
    clr = 1'b1; cyc(1); clr = 1'b0;
    check("clr_sb_cnt", bus.sb_cnt_o, 0);
    check("clr_db_cnt", bus.db_cnt_o, 0);

    // clr_i lands in the same cycle as the host double-error event.
    bus.host_req_i = 1'b1; bus.host_addr_i = 8'h20;
    #1;
    check("clr_coinc_gnt", bus.host_gnt_o, 1);
    cyc(1);
    bus.host_req_i = 1'b0; clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    $display("host read addr=20 with clr -> valid=%b db=%b db_cnt=%0d",
             bus.rsp_valid_o, bus.rsp_db_err_o, bus.db_cnt_o);
    check("clr_coinc_valid", bus.rsp_valid_o, 1);
    check("clr_coinc_db_flag", bus.rsp_db_err_o, 1);
    check("clr_coinc_db_cnt", bus.db_cnt_o, 0);
    cyc(2);

    w0 = wr_cnt;
    scrub_en = 1'b1;
    t = 0;
    while (!bus.db_irq_o && t < 1000) begin cyc(1); t++; end
    $display("scrub db event: irq=%b addr=%02h db_cnt=%0d after %0d cycles",
             bus.db_irq_o, bus.db_addr_o, bus.db_cnt_o, t);
    check("scrub_db_irq", bus.db_irq_o, 1);
    check("scrub_db_addr", bus.db_addr_o, 8'h20);
    check("scrub_db_cnt", bus.db_cnt_o, 1);
    check("scrub_sb_cnt", bus.sb_cnt_o, 0);
    check("scrub_no_write", wr_cnt - w0, 0);
    scrub_en = 1'b0;
    cyc(3);
    clr = 1'b1; cyc(1); clr = 1'b0;
    check("clr_db_irq", bus.db_irq_o, 0);
    check("clr_db_cnt2", bus.db_cnt_o, 0);
    cyc(2);

    // Reset asserted while the write-back cycle is on the bus.
    preload(8'h30, enc(4'h5) ^ 8'h20);
    w0 = wr_cnt;
    bus.host_req_i = 1'b1; bus.host_addr_i = 8'h30;
    #1;
    check("wbrst_gnt", bus.host_gnt_o, 1);
    cyc(1);
    bus.host_req_i = 1'b0;
    cyc(1);
    check("wbrst_in_wb", bus.mem_we_o, 1);
    check("wbrst_sb_cnt", bus.sb_cnt_o, 1);
    rst_n = 1'b0;
    #1;
    check("wbrst_mem_req", bus.mem_req_o, 0);
    check("wbrst_sb_cnt_cleared", bus.sb_cnt_o, 0);
    check("wbrst_rsp_valid", bus.rsp_valid_o, 0);
    cyc(2);
    check("wbrst_no_write", wr_cnt - w0, 0);
    check("wbrst_mem_kept", mem1[8'h30], enc(4'h5) ^ 8'h20);
    rst_n = 1'b1;
    cyc(1);
    $display("reset during write-back: mem[30]=%02h writes=%0d", mem1[8'h30], wr_cnt - w0);

    // Continuous host traffic against periodic scrub slots.
    bus.host_req_i = 1'b1; bus.host_addr_i = 8'h05; scrub_en = 1'b1; log_en = 1'b1;
    cyc(60);
    bus.host_req_i = 1'b0; scrub_en = 1'b0;
    ns = 0; nh = 0; cons = 0;
    for (int i = 0; i < nlog; i++) begin
      if (log_host[i]) nh++;
      else begin
        if (ns < 3) check($sformatf("alt_scrub_ptr%0d", ns), log_addr[i], ns);
        ns++;
        if (i == 0) cons++;
        else if (!log_host[i-1]) cons++;
      end
    end
    $display("arbitration: %0d host reads, %0d scrub reads, %0d unfair slots", nh, ns, cons);
    check("alt_no_back_to_back_scrub", cons, 0);
    check("alt_scrub_slots_in_range", (ns >= 6 && ns <= 8), 1);
    check("alt_host_not_starved", (nh >= 2 * ns), 1);
    log_en = 1'b0;
    cyc(4);

    // 4-word instance: pointer wrap and 2-bit counter saturation.
    scrub_en2 = 1'b1; log2_en = 1'b1;
    t = 0;
    while (n2 < 5 && t < 100) begin cyc(1); t++; end
    scrub_en2 = 1'b0;
    check("wrap_slots_seen", (n2 >= 5), 1);
    for (int i = 0; i < 5; i++) begin
      $display("small scrub slot %0d addr=%0d", i, log2_addr[i]);
      check($sformatf("wrap_ptr%0d", i), log2_addr[i], (i == 4) ? 0 : i);
    end
    cyc(3);
    check("sat_db_cnt", bus2.db_cnt_o, 3);
    check("sat_db_irq", bus2.db_irq_o, 1);
    check("sat_db_addr", bus2.db_addr_o, 0);
    log2_en = 1'b0;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
